// File: rtl/ft600_reg_bridge_if.sv
// Bundle of the PHY FIFO strobes and the register-bus signals used by the
// FT600 register bridge. The bridge is the master; the PHY FIFOs and the
// register file together form the slave side.
interface ft600_reg_bridge_if;
    logic        rx_empty;
    logic        rx_en;
    logic [15:0] rx_data;
    logic        tx_full;
    logic        tx_en;
    logic [15:0] tx_data;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;

    modport master (
        input  rx_empty, rx_data, tx_full, reg_rdata,
        output rx_en, tx_en, tx_data, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output rx_empty, rx_data, tx_full, reg_rdata,
        input  rx_en, tx_en, tx_data, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/ft600_reg_bridge.sv
// FT600 command decoder: pops header/payload words from the PHY RX FIFO,
// drives a single-cycle register bus and pushes READ/SYNC responses into the
// PHY TX FIFO. Every strobe is a registered one-cycle pulse, so a state that
// consumes popped data (or bus read data) first lets the pending strobe
// retire for one cycle before sampling.
module ft600_reg_bridge #(
    parameter logic [15:0] SYNC_WORD = 16'hF600,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    ft600_reg_bridge_if.master        bus_if,
    output logic                      busy_o,
    output logic [7:0]                err_count_o
);
    localparam int unsigned TW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_SYNC  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_WR_POP  = 3'd2,
        S_WR_DATA = 3'd3,
        S_RD_HDR  = 3'd4,
        S_RD_REQ  = 3'd5,
        S_RD_DATA = 3'd6,
        S_SYNC    = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   hdr_q, hdr_d;
    logic [5:0]    k_q, k_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   hold_q, hold_d;
    logic          held_q, held_d;
    logic          rx_en_q, rx_en_d;
    logic          tx_en_q, tx_en_d;
    logic [15:0]   tx_data_q, tx_data_d;
    logic [7:0]    reg_addr_q, reg_addr_d;
    logic [15:0]   reg_wdata_q, reg_wdata_d;
    logic          reg_we_q, reg_we_d;
    logic          reg_re_q, reg_re_d;
    logic          busy_q, busy_d;
    logic [7:0]    err_q, err_d;

    logic [5:0]    len_s;
    logic [5:0]    k_inc_s;
    logic [7:0]    addr_k_s;
    logic [15:0]   rd_word_s;

    assign len_s     = hdr_q[13:8];
    assign k_inc_s   = k_q + 6'd1;
    assign addr_k_s  = hdr_q[7:0] + {2'b00, k_q};
    assign rd_word_s = held_q ? hold_q : bus_if.reg_rdata;

    // Next-state decode and registered-output computation for the packet FSM.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        k_d         = k_q;
        tmo_d       = tmo_q;
        hold_d      = hold_q;
        held_d      = held_q;
        rx_en_d     = 1'b0;
        tx_en_d     = 1'b0;
        tx_data_d   = tx_data_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                k_d    = 6'd0;
                tmo_d  = '0;
                held_d = 1'b0;
                if (!bus_if.rx_empty) begin
                    rx_en_d = 1'b1;
                    state_d = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                // Header word arrives the cycle after the pop strobe retires.
                if (rx_en_q) begin
                    state_d = S_HDR;
                end else begin
                    hdr_d = bus_if.rx_data;
                    case (op_e'(bus_if.rx_data[15:14]))
                        OP_NOP:   state_d = S_IDLE;
                        OP_WRITE: state_d = (bus_if.rx_data[13:8] == 6'd0) ? S_IDLE : S_WR_POP;
                        OP_READ:  state_d = S_RD_HDR;
                        OP_SYNC:  state_d = S_SYNC;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_WR_POP: begin
                if (!bus_if.rx_empty) begin
                    rx_en_d = 1'b1;
                    tmo_d   = '0;
                    state_d = S_WR_DATA;
                end else if ((TIMEOUT != 32'd0) && (tmo_q == TMO_LAST)) begin
                    // Host stopped sending payload: abandon the packet.
                    tmo_d   = '0;
                    state_d = S_IDLE;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1'b1);
                end
            end
            S_WR_DATA: begin
                if (rx_en_q) begin
                    state_d = S_WR_DATA;
                end else begin
                    reg_we_d    = 1'b1;
                    reg_wdata_d = bus_if.rx_data;
                    reg_addr_d  = addr_k_s;
                    k_d         = k_inc_s;
                    if (k_inc_s == len_s) begin
                        state_d = S_IDLE;
                    end else if (!bus_if.rx_empty) begin
                        // Next payload word is already waiting: pop it now.
                        rx_en_d = 1'b1;
                        state_d = S_WR_DATA;
                    end else begin
                        state_d = S_WR_POP;
                    end
                end
            end
            S_RD_HDR: begin
                if (!bus_if.tx_full) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = hdr_q;
                    state_d   = (len_s == 6'd0) ? S_IDLE : S_RD_REQ;
                end else begin
                    state_d = S_RD_HDR;
                end
            end
            S_RD_REQ: begin
                reg_re_d   = 1'b1;
                reg_addr_d = addr_k_s;
                state_d    = S_RD_DATA;
            end
            S_RD_DATA: begin
                // Read data is valid only in the cycle after the read strobe;
                // capture it once so a TX stall cannot lose it.
                if (reg_re_q) begin
                    state_d = S_RD_DATA;
                end else begin
                    if (!held_q) begin
                        hold_d = bus_if.reg_rdata;
                        held_d = 1'b1;
                    end else begin
                        hold_d = hold_q;
                    end
                    if (!bus_if.tx_full) begin
                        tx_en_d   = 1'b1;
                        tx_data_d = rd_word_s;
                        held_d    = 1'b0;
                        k_d       = k_inc_s;
                        state_d   = (k_inc_s == len_s) ? S_IDLE : S_RD_REQ;
                    end else begin
                        state_d = S_RD_DATA;
                    end
                end
            end
            S_SYNC: begin
                if (!bus_if.tx_full) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = SYNC_WORD;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_SYNC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hdr_q       <= 16'h0000;
            k_q         <= 6'd0;
            tmo_q       <= '0;
            hold_q      <= 16'h0000;
            held_q      <= 1'b0;
            rx_en_q     <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= 16'h0000;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 16'h0000;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            held_q      <= held_d;
            rx_en_q     <= rx_en_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus_if.rx_en     = rx_en_q;
    assign bus_if.tx_en     = tx_en_q;
    assign bus_if.tx_data   = tx_data_q;
    assign bus_if.reg_addr  = reg_addr_q;
    assign bus_if.reg_wdata = reg_wdata_q;
    assign bus_if.reg_we    = reg_we_q;
    assign bus_if.reg_re    = reg_re_q;
    assign busy_o           = busy_q;
    assign err_count_o      = err_q;
endmodule

// File: tb/tb_ft600_reg_bridge.sv
// Directed bench for ft600_reg_bridge: RX FIFO model, TX capture, register
// file model returning addr*2 on reads, and hand-computed expectations.
module tb_ft600_reg_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic       tx_full_s;
    logic       busy;
    logic [7:0] err_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ft600_reg_bridge_if bus_if();

    ft600_reg_bridge #(.SYNC_WORD(16'hF600), .TIMEOUT(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_if      (bus_if),
        .busy_o      (busy),
        .err_count_o (err_count)
    );

    // RX FIFO model: pop on rx_en, data visible the following cycle.
    logic [15:0] rx_mem [0:63];
    int rx_wr   = 0;
    int rx_rd   = 0;
    int rx_viol = 0;
    assign bus_if.rx_empty = (rx_wr == rx_rd);
    assign bus_if.tx_full  = tx_full_s;

    always @(posedge clk) begin
        if (bus_if.rx_en) begin
            if (rx_wr == rx_rd) begin
                rx_viol <= rx_viol + 1;
            end else begin
                bus_if.rx_data <= rx_mem[rx_rd[5:0]];
                rx_rd          <= rx_rd + 1;
            end
        end
    end

    // Register file and TX capture models.
    logic [7:0]  we_addr [0:63];
    logic [15:0] we_data [0:63];
    logic [15:0] tx_log  [0:63];
    int we_cnt  = 0;
    int re_cnt  = 0;
    int tx_cnt  = 0;
    int tx_viol = 0;

    always @(posedge clk) begin
        if (bus_if.reg_we) begin
            we_addr[we_cnt[5:0]] <= bus_if.reg_addr;
            we_data[we_cnt[5:0]] <= bus_if.reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (bus_if.reg_re) begin
            bus_if.reg_rdata <= {7'd0, bus_if.reg_addr, 1'b0};
            re_cnt <= re_cnt + 1;
        end else begin
            bus_if.reg_rdata <= 16'hDEAD;
        end
        if (bus_if.tx_en) begin
            tx_log[tx_cnt[5:0]] <= bus_if.tx_data;
            tx_cnt <= tx_cnt + 1;
            if (bus_if.tx_full) tx_viol <= tx_viol + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic rx_push(input logic [15:0] w);
        rx_mem[rx_wr[5:0]] = w;
        rx_wr = rx_wr + 1;
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return tx_cnt;
            1:       return re_cnt;
            default: return we_cnt;
        endcase
    endfunction

    // Wait (bounded) until the chosen counter reaches target.
    task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
        int n;
        n = 0;
        while (cnt_of(which) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 32'(n < budget), 32'd1);
    endtask

    // Wait (bounded) until the DUT is idle with nothing left to pop.
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((busy || !bus_if.rx_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk_eq(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_tx, b_re, b_we;
        rst       = 1'b1;
        tx_full_s = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_rx_en",     32'(bus_if.rx_en),     32'd0);
        chk_eq("rst_tx_en",     32'(bus_if.tx_en),     32'd0);
        chk_eq("rst_tx_data",   32'(bus_if.tx_data),   32'd0);
        chk_eq("rst_reg_we",    32'(bus_if.reg_we),    32'd0);
        chk_eq("rst_reg_re",    32'(bus_if.reg_re),    32'd0);
        chk_eq("rst_reg_addr",  32'(bus_if.reg_addr),  32'd0);
        chk_eq("rst_reg_wdata", 32'(bus_if.reg_wdata), 32'd0);
        chk_eq("rst_busy",      32'(busy),             32'd0);
        chk_eq("rst_err",       32'(err_count),        32'd0);
        rst = 1'b0;

        // WRITE len 3 at FE with address wrap
        b_tx = tx_cnt; b_we = we_cnt;
        rx_push(16'h43FE); rx_push(16'h1111); rx_push(16'h2222); rx_push(16'h3333);
        wait_idle("wr_idle", 200);
        chk_eq("wr_count", 32'(we_cnt - b_we), 32'd3);
        chk_eq("wr0_addr", 32'(we_addr[6'(b_we)]),     32'h00FE);
        chk_eq("wr0_data", 32'(we_data[6'(b_we)]),     32'h1111);
        chk_eq("wr1_addr", 32'(we_addr[6'(b_we + 1)]), 32'h00FF);
        chk_eq("wr1_data", 32'(we_data[6'(b_we + 1)]), 32'h2222);
        chk_eq("wr2_addr", 32'(we_addr[6'(b_we + 2)]), 32'h0000);
        chk_eq("wr2_data", 32'(we_data[6'(b_we + 2)]), 32'h3333);
        chk_eq("wr_no_tx", 32'(tx_cnt - b_tx), 32'd0);
        chk_eq("wr_busy",  32'(busy), 32'd0);

        // READ len 2 at 10
        b_tx = tx_cnt; b_re = re_cnt;
        rx_push(16'h8210);
        wait_idle("rd_idle", 200);
        chk_eq("rd_tx_count", 32'(tx_cnt - b_tx), 32'd3);
        chk_eq("rd_hdr",  32'(tx_log[6'(b_tx)]),     32'h8210);
        chk_eq("rd_d0",   32'(tx_log[6'(b_tx + 1)]), 32'h0020);
        chk_eq("rd_d1",   32'(tx_log[6'(b_tx + 2)]), 32'h0022);
        chk_eq("rd_re_count", 32'(re_cnt - b_re), 32'd2);

        // SYNC, NOP, len-0 READ
        b_tx = tx_cnt; b_re = re_cnt; b_we = we_cnt;
        rx_push(16'hC000); rx_push(16'h0000); rx_push(16'h8005);
        wait_idle("snr_idle", 200);
        chk_eq("snr_tx_count", 32'(tx_cnt - b_tx), 32'd2);
        chk_eq("snr_sync", 32'(tx_log[6'(b_tx)]),     32'hF600);
        chk_eq("snr_hdr0", 32'(tx_log[6'(b_tx + 1)]), 32'h8005);
        chk_eq("snr_no_re", 32'(re_cnt - b_re), 32'd0);
        chk_eq("snr_no_we", 32'(we_cnt - b_we), 32'd0);

        // TX backpressure mid-burst: READ len 4 at 40
        b_tx = tx_cnt; b_re = re_cnt;
        rx_push(16'h8440);
        wait_cnt("bp_first_data", 0, b_tx + 2, 200);
        tx_full_s = 1'b1;
        repeat (50) @(negedge clk);
        chk_eq("bp_stalled", 32'(tx_cnt - b_tx), 32'd2);
        chk_eq("bp_busy",    32'(busy), 32'd1);
        tx_full_s = 1'b0;
        wait_idle("bp_idle", 200);
        chk_eq("bp_tx_count", 32'(tx_cnt - b_tx), 32'd5);
        chk_eq("bp_hdr", 32'(tx_log[6'(b_tx)]),     32'h8440);
        chk_eq("bp_d0",  32'(tx_log[6'(b_tx + 1)]), 32'h0080);
        chk_eq("bp_d1",  32'(tx_log[6'(b_tx + 2)]), 32'h0082);
        chk_eq("bp_d2",  32'(tx_log[6'(b_tx + 3)]), 32'h0084);
        chk_eq("bp_d3",  32'(tx_log[6'(b_tx + 4)]), 32'h0086);
        chk_eq("bp_re_count", 32'(re_cnt - b_re), 32'd4);

        // Timeout: WRITE len 5 at 05 with only two payload words
        b_tx = tx_cnt; b_we = we_cnt;
        rx_push(16'h4505); rx_push(16'h0A0A); rx_push(16'h0B0B);
        wait_cnt("to_writes", 2, b_we + 2, 200);
        repeat (14) @(negedge clk);
        chk_eq("to_busy_before", 32'(busy), 32'd1);
        chk_eq("to_err_before",  32'(err_count), 32'd0);
        @(negedge clk);
        chk_eq("to_busy_after",  32'(busy), 32'd0);
        chk_eq("to_err_after",   32'(err_count), 32'd1);
        chk_eq("to_we_count", 32'(we_cnt - b_we), 32'd2);
        chk_eq("to_w0_addr", 32'(we_addr[6'(b_we)]),     32'h0005);
        chk_eq("to_w0_data", 32'(we_data[6'(b_we)]),     32'h0A0A);
        chk_eq("to_w1_addr", 32'(we_addr[6'(b_we + 1)]), 32'h0006);
        chk_eq("to_w1_data", 32'(we_data[6'(b_we + 1)]), 32'h0B0B);
        chk_eq("to_no_tx", 32'(tx_cnt - b_tx), 32'd0);
        rx_push(16'hC000);
        wait_idle("to_sync_idle", 200);
        chk_eq("to_sync_count", 32'(tx_cnt - b_tx), 32'd1);
        chk_eq("to_sync_word",  32'(tx_log[6'(b_tx)]), 32'hF600);

        // Reset in the middle of a READ len 3 at 30
        b_tx = tx_cnt; b_re = re_cnt; b_we = we_cnt;
        rx_push(16'h8330);
        wait_cnt("mr_first_re", 1, b_re + 1, 200);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mr_busy",   32'(busy), 32'd0);
        chk_eq("mr_tx_en",  32'(bus_if.tx_en), 32'd0);
        chk_eq("mr_reg_re", 32'(bus_if.reg_re), 32'd0);
        chk_eq("mr_err_cleared", 32'(err_count), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_eq("mr_tx_count", 32'(tx_cnt - b_tx), 32'd1);
        chk_eq("mr_re_count", 32'(re_cnt - b_re), 32'd1);
        chk_eq("mr_we_count", 32'(we_cnt - b_we), 32'd0);
        chk_eq("mr_still_idle", 32'(busy), 32'd0);

        // FIFO strobe rules over the whole run
        chk_eq("rx_pop_when_empty", 32'(rx_viol), 32'd0);
        chk_eq("tx_push_when_full", 32'(tx_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
